// File: rtl/carfield_jtag_dtm_responder_if.sv
// ----------------------------------------------------------------------------
// carfield_jtag_dtm_responder_if : DMI request/response channel between DTM and DM
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface carfield_jtag_dtm_responder_if #(
  parameter int unsigned ABITS_W = 7
);
  logic               req_valid;
  logic               req_ready;
  logic [ABITS_W-1:0] req_addr;
  logic [31:0]        req_data;
  logic [1:0]         req_op;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [31:0]        rsp_data;
  logic [1:0]         rsp_resp;

  modport master (
    output req_valid, req_addr, req_data, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_resp
  );

  modport slave (
    input  req_valid, req_addr, req_data, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_resp
  );
endinterface

`default_nettype wire

// File: rtl/carfield_jtag_dtm_responder.sv
// ----------------------------------------------------------------------------
// carfield_jtag_dtm_responder : RISC-V 0.13 JTAG DTM (TAP, IDCODE/DTMCS/DMI/BYPASS)
// Optional: CARFIELD_DTM_HARDRESET_EN enables dtmcs.dmihardreset handling.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module carfield_jtag_dtm_responder #(
  parameter logic [31:0] IDCODE_VALUE = 32'h0000_0DB3,
  parameter int unsigned ABITS_W      = 7,
  parameter int unsigned IR_LENGTH    = 5
) (
  input  logic                          tck_i,
  input  logic                          rst_n,
  input  logic                          trst_ni,
  input  logic                          tms_i,
  input  logic                          tdi_i,
  output logic                          tdo_o,
  output logic                          tdo_oe_o,
  carfield_jtag_dtm_responder_if.master dmi,
  output logic                          dmi_rst_no
);

  localparam int unsigned          DR_W        = ABITS_W + 34;
  localparam logic [IR_LENGTH-1:0] IR_IDCODE   = IR_LENGTH'(5'h01);
  localparam logic [IR_LENGTH-1:0] IR_DTMCS    = IR_LENGTH'(5'h10);
  localparam logic [IR_LENGTH-1:0] IR_DMI      = IR_LENGTH'(5'h11);
  localparam logic [IR_LENGTH-1:0] IR_CAPTURE  = IR_LENGTH'(5'b00101);
  localparam logic [5:0]           ABITS_FIELD = 6'(ABITS_W);

  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAUSE_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PAUSE_IR, EX2_IR, UPD_IR
  } tap_state_e;

  typedef enum logic [1:0] {REQ_IDLE, REQ_SEND, REQ_RSP} req_state_e;

  logic                 w_rst_n;
  tap_state_e           r_tap, w_tap_next;
  req_state_e           r_req, w_req_next;
  logic [IR_LENGTH-1:0] r_ir, r_ir_shift;
  logic [DR_W-1:0]      r_dr, w_dr_next;
  logic [ABITS_W-1:0]   r_addr, r_req_addr;
  logic [31:0]          r_rdata, r_req_data;
  logic [1:0]           r_req_op, r_dmistat, w_stat;
  logic [31:0]          w_dtmcs_cap;
  logic                 w_busy, w_upd_dmi, w_upd_dtmcs, w_issue, w_busy_err;
  logic                 w_dmireset, w_hardreset, w_rsp_hs;
  logic                 w_req_valid, w_rsp_ready;

  // Either reset source (system or JTAG) clears the whole block.
  assign w_rst_n = rst_n & trst_ni;

  always_ff @(posedge tck_i or negedge w_rst_n) begin
    if (!w_rst_n) r_tap <= TLR;
    else          r_tap <= w_tap_next;
  end

  always_comb begin
    w_tap_next = r_tap;
    case (r_tap)
      TLR:      w_tap_next = tms_i ? TLR    : RTI;
      RTI:      w_tap_next = tms_i ? SEL_DR : RTI;
      SEL_DR:   w_tap_next = tms_i ? SEL_IR : CAP_DR;
      CAP_DR:   w_tap_next = tms_i ? EX1_DR : SH_DR;
      SH_DR:    w_tap_next = tms_i ? EX1_DR : SH_DR;
      EX1_DR:   w_tap_next = tms_i ? UPD_DR : PAUSE_DR;
      PAUSE_DR: w_tap_next = tms_i ? EX2_DR : PAUSE_DR;
      EX2_DR:   w_tap_next = tms_i ? UPD_DR : SH_DR;
      UPD_DR:   w_tap_next = tms_i ? SEL_DR : RTI;
      SEL_IR:   w_tap_next = tms_i ? TLR    : CAP_IR;
      CAP_IR:   w_tap_next = tms_i ? EX1_IR : SH_IR;
      SH_IR:    w_tap_next = tms_i ? EX1_IR : SH_IR;
      EX1_IR:   w_tap_next = tms_i ? UPD_IR : PAUSE_IR;
      PAUSE_IR: w_tap_next = tms_i ? EX2_IR : PAUSE_IR;
      EX2_IR:   w_tap_next = tms_i ? UPD_IR : SH_IR;
      UPD_IR:   w_tap_next = tms_i ? SEL_DR : RTI;
      default:  w_tap_next = TLR;
    endcase
  end

  assign w_busy      = (r_req != REQ_IDLE);
  assign w_stat      = (r_dmistat != 2'd0) ? r_dmistat : (w_busy ? 2'd3 : 2'd0);
  assign w_dtmcs_cap = {14'b0, 3'b0, 3'd1, r_dmistat, ABITS_FIELD, 4'd1};

  always_comb begin
    w_dr_next = r_dr;
    if (r_tap == CAP_DR) begin
      case (r_ir)
        IR_IDCODE: w_dr_next = DR_W'(IDCODE_VALUE | 32'h1);
        IR_DTMCS:  w_dr_next = DR_W'(w_dtmcs_cap);
        IR_DMI:    w_dr_next = {r_addr, r_rdata, w_stat};
        default:   w_dr_next = '0;
      endcase
    end else if (r_tap == SH_DR) begin
      case (r_ir)
        IR_IDCODE, IR_DTMCS: w_dr_next = DR_W'({tdi_i, r_dr[31:1]});
        IR_DMI:              w_dr_next = {tdi_i, r_dr[DR_W-1:1]};
        default:             w_dr_next = DR_W'(tdi_i);
      endcase
    end
  end

  always_ff @(posedge tck_i or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_ir       <= IR_IDCODE;
      r_ir_shift <= '0;
      r_dr       <= '0;
    end else begin
      r_dr <= w_dr_next;
      if (r_tap == TLR)         r_ir <= IR_IDCODE;
      else if (r_tap == UPD_IR) r_ir <= r_ir_shift;
      if (r_tap == CAP_IR)      r_ir_shift <= IR_CAPTURE;
      else if (r_tap == SH_IR)  r_ir_shift <= {tdi_i, r_ir_shift[IR_LENGTH-1:1]};
    end
  end

  always_ff @(negedge tck_i or negedge w_rst_n) begin
    if (!w_rst_n) tdo_o <= 1'b0;
    else          tdo_o <= (r_tap == SH_IR) ? r_ir_shift[0] : r_dr[0];
  end

  assign tdo_oe_o = (r_tap == SH_IR) || (r_tap == SH_DR);

  assign w_upd_dmi   = (r_tap == UPD_DR) && (r_ir == IR_DMI);
  assign w_upd_dtmcs = (r_tap == UPD_DR) && (r_ir == IR_DTMCS);
  assign w_issue     = w_upd_dmi && (r_dmistat == 2'd0) && !w_busy &&
                       ((r_dr[1:0] == 2'd1) || (r_dr[1:0] == 2'd2));
  assign w_busy_err  = w_upd_dmi && (r_dmistat == 2'd0) && w_busy;
  assign w_dmireset  = w_upd_dtmcs && r_dr[16];
  assign w_rsp_hs    = (r_req == REQ_RSP) && dmi.rsp_valid;

`ifdef CARFIELD_DTM_HARDRESET_EN
  logic r_dmi_rst_n;
  assign w_hardreset = w_upd_dtmcs && r_dr[17];

  always_ff @(posedge tck_i or negedge w_rst_n) begin
    if (!w_rst_n) r_dmi_rst_n <= 1'b1;
    else          r_dmi_rst_n <= !w_hardreset;
  end
  assign dmi_rst_no = r_dmi_rst_n;
`else
  assign w_hardreset = 1'b0;
  assign dmi_rst_no  = 1'b1;
`endif

  always_ff @(posedge tck_i or negedge w_rst_n) begin
    if (!w_rst_n) r_req <= REQ_IDLE;
    else          r_req <= w_req_next;
  end

  // Request and response phases are separate states so both handshakes never close together.
  always_comb begin
    w_req_next  = r_req;
    w_req_valid = 1'b0;
    w_rsp_ready = 1'b0;
    case (r_req)
      REQ_IDLE: if (w_issue) w_req_next = REQ_SEND;
      REQ_SEND: begin
        w_req_valid = 1'b1;
        if (dmi.req_ready) w_req_next = REQ_RSP;
      end
      REQ_RSP: begin
        w_rsp_ready = 1'b1;
        if (dmi.rsp_valid) w_req_next = REQ_IDLE;
      end
      default: w_req_next = REQ_IDLE;
    endcase
    if (w_hardreset) w_req_next = REQ_IDLE;
  end

  always_ff @(posedge tck_i or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_req_addr <= '0;
      r_req_data <= '0;
      r_req_op   <= '0;
      r_addr     <= '0;
      r_rdata    <= '0;
      r_dmistat  <= '0;
    end else begin
      if (w_issue) begin
        r_req_addr <= r_dr[DR_W-1:34];
        r_req_data <= r_dr[33:2];
        r_req_op   <= r_dr[1:0];
        r_addr     <= r_dr[DR_W-1:34];
      end
      if (w_rsp_hs) r_rdata <= dmi.rsp_data;
      if (w_dmireset || w_hardreset)             r_dmistat <= 2'd0;
      else if (w_busy_err)                       r_dmistat <= 2'd3;
      else if (w_rsp_hs && dmi.rsp_resp == 2'd2) r_dmistat <= 2'd2;
    end
  end

  assign dmi.req_valid = w_req_valid;
  assign dmi.req_addr  = r_req_addr;
  assign dmi.req_data  = r_req_data;
  assign dmi.req_op    = r_req_op;
  assign dmi.rsp_ready = w_rsp_ready;

endmodule

`default_nettype wire
